// File: rtl/cpu_clock_gen.sv
`default_nettype none
// cpu_clock_gen: CPU clock source (free-run or single-step) with glitch-free halt
// and single-cycle rise/fall strobes, all in the fastClk domain.  Rev 1.0
module cpu_clock_gen #(
  parameter int BASE_HALF_PERIOD = 6000000,
  parameter int SPEED_W          = 2,
  parameter int DEBOUNCE_CYCLES  = 12000,
  parameter int PULSE_CYCLES     = 600000
) (
  input  logic               fastClk,
  input  logic               resetN,
  input  logic               runMode,
  input  logic [SPEED_W-1:0] speedSel,
  input  logic               stepButton,
  input  logic               halt,
  output logic               cpuClk,
  output logic               clkRise,
  output logic               clkFall,
  output logic               halted
);

  localparam int CNT_MAX    = (BASE_HALF_PERIOD > PULSE_CYCLES) ? BASE_HALF_PERIOD : PULSE_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int DEB_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ARM_CYCLES = DEBOUNCE_CYCLES + 2;
  localparam int ARM_W      = $clog2(ARM_CYCLES);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_HIGH_RUN  = 2'd1,
    ST_HIGH_STEP = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] half_period(input logic [SPEED_W-1:0] sel);
    int h;
    h = BASE_HALF_PERIOD >> (2 * int'(sel));
    if (h < 1) h = 1;
    return CNT_W'(h);
  endfunction

  // Button path registers
  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             armed_q, armed_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             press_w;

  // Clock generator registers
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hper_q, hper_d;
  logic [CNT_W-1:0] cnt_base, h_use, h_live;
  logic             active_mode_q, active_mode_d;
  logic             cpu_clk_q, cpu_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             halted_q, halted_d;

  assign h_live = half_period(speedSel);

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // After reset the button must be seen released before a press can count,
  // so a button held through reset never produces a step pulse.
  always_comb begin
    armed_d   = armed_q;
    arm_cnt_d = arm_cnt_q;
    if (!armed_q) begin
      if (sync2_q || deb_q) begin
        arm_cnt_d = '0;
      end else if (arm_cnt_q == ARM_W'(ARM_CYCLES - 1)) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + ARM_W'(1);
      end
    end
  end

  assign press_w = armed_q & deb_q & ~deb_prev_q;

  always_ff @(posedge fastClk or negedge resetN) begin
    if (!resetN) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
      armed_q    <= 1'b0;
      arm_cnt_q  <= '0;
    end else begin
      sync1_q    <= stepButton;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
      armed_q    <= armed_d;
      arm_cnt_q  <= arm_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hper_d        = hper_q;
    active_mode_d = active_mode_q;
    cpu_clk_d     = cpu_clk_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    cnt_base      = cnt_q;
    h_use         = hper_q;

    unique case (state_q)
      ST_LOW: begin
        active_mode_d = runMode;
        if (runMode && !active_mode_q) cnt_base = '0;
        // A phase latches its length from speedSel on its first cycle only.
        h_use = (cnt_base == '0) ? h_live : hper_q;
        if (halt) begin
          cnt_d = '0;
        end else if (runMode) begin
          hper_d = h_use;
          if (cnt_base == h_use - CNT_W'(1)) begin
            state_d   = ST_HIGH_RUN;
            cnt_d     = '0;
            cpu_clk_d = 1'b1;
            rise_d    = 1'b1;
          end else begin
            cnt_d = cnt_base + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
          if (press_w) begin
            state_d   = ST_HIGH_STEP;
            cpu_clk_d = 1'b1;
            rise_d    = 1'b1;
          end
        end
      end

      ST_HIGH_RUN: begin
        h_use  = (cnt_q == '0) ? h_live : hper_q;
        hper_d = h_use;
        if (cnt_q == h_use - CNT_W'(1)) begin
          state_d   = ST_LOW;
          cnt_d     = '0;
          cpu_clk_d = 1'b0;
          fall_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HIGH_STEP: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          state_d   = ST_LOW;
          cnt_d     = '0;
          cpu_clk_d = 1'b0;
          fall_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_LOW;
        cnt_d     = '0;
        cpu_clk_d = 1'b0;
      end
    endcase
  end

  assign halted_d = halt & ~cpu_clk_d;

  always_ff @(posedge fastClk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_LOW;
      cnt_q         <= '0;
      hper_q        <= '0;
      active_mode_q <= 1'b0;
      cpu_clk_q     <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hper_q        <= hper_d;
      active_mode_q <= active_mode_d;
      cpu_clk_q     <= cpu_clk_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      halted_q      <= halted_d;
    end
  end

  assign cpuClk  = cpu_clk_q;
  assign clkRise = rise_q;
  assign clkFall = fall_q;
  assign halted  = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_gen.sv
`default_nettype none
// tb_cpu_clock_gen: directed vectors for cpu_clock_gen with small parameters.
module tb_cpu_clock_gen;

  localparam int BASE  = 64;
  localparam int DEB   = 4;
  localparam int PULSE = 3;
  localparam int SW    = 2;

  logic          fastClk = 1'b0;
  logic          resetN;
  logic          runMode;
  logic [SW-1:0] speedSel;
  logic          stepButton;
  logic          halt;
  logic          cpuClk, clkRise, clkFall, halted;

  int n_vec  = 0;
  int n_miss = 0;
  int rise_cnt = 0, fall_cnt = 0, both_cnt = 0, dup_cnt = 0;
  logic prev_rise = 1'b0, prev_fall = 1'b0;

  always #5 fastClk = ~fastClk;

  cpu_clock_gen #(
    .BASE_HALF_PERIOD(BASE),
    .SPEED_W         (SW),
    .DEBOUNCE_CYCLES (DEB),
    .PULSE_CYCLES    (PULSE)
  ) u_dut (
    .fastClk   (fastClk),
    .resetN    (resetN),
    .runMode   (runMode),
    .speedSel  (speedSel),
    .stepButton(stepButton),
    .halt      (halt),
    .cpuClk    (cpuClk),
    .clkRise   (clkRise),
    .clkFall   (clkFall),
    .halted    (halted)
  );

  // Strobe bookkeeping, sampled mid-cycle
  always @(negedge fastClk) begin
    if (clkRise) rise_cnt <= rise_cnt + 1;
    if (clkFall) fall_cnt <= fall_cnt + 1;
    if (clkRise && clkFall) both_cnt <= both_cnt + 1;
    if ((clkRise && prev_rise) || (clkFall && prev_fall)) dup_cnt <= dup_cnt + 1;
    prev_rise <= clkRise;
    prev_fall <= clkFall;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts clock edges until cpuClk reaches lvl (bounded by limit)
  task automatic run_until(input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      @(posedge fastClk);
      #1;
      n++;
    end while (cpuClk !== lvl && n < limit);
    if (cpuClk !== lvl) n = limit + 1;
  endtask

  task automatic do_reset();
    @(negedge fastClk);
    resetN = 1'b0;
    repeat (2) @(negedge fastClk);
    resetN = 1'b1;
  endtask

  initial begin
    int n, r0, f0;
    resetN     = 1'b0;
    runMode    = 1'b1;
    speedSel   = 2'd0;
    stepButton = 1'b0;
    halt       = 1'b0;
    #22;
    check_vec("rst_cpuClk", 32'(cpuClk), 0);
    check_vec("rst_clkRise", 32'(clkRise), 0);
    check_vec("rst_clkFall", 32'(clkFall), 0);
    check_vec("rst_halted", 32'(halted), 0);

    // Run mode, speedSel=0
    @(negedge fastClk);
    resetN = 1'b1;
    run_until(1'b1, 200, n);
    check_vec("run_first_rise", n, 64);
    check_vec("run_rise_strobe", 32'(clkRise), 1);
    check_vec("run_rise_nofall", 32'(clkFall), 0);
    run_until(1'b0, 200, n);
    check_vec("run_high", n, 64);
    check_vec("run_fall_strobe", 32'(clkFall), 1);
    run_until(1'b1, 200, n);
    check_vec("run_low", n, 64);
    repeat (10) @(posedge fastClk);
    @(negedge fastClk);
    speedSel = 2'd2;
    run_until(1'b0, 200, n);
    check_vec("high_keeps_len", n, 54);
    run_until(1'b1, 200, n);
    check_vec("low_fast", n, 4);
    run_until(1'b0, 200, n);
    check_vec("high_fast", n, 4);
    run_until(1'b1, 200, n);
    check_vec("low_fast2", n, 4);
    @(posedge fastClk);
    @(negedge fastClk);
    speedSel = 2'd0;
    run_until(1'b0, 200, n);
    check_vec("fast_keeps_len", n, 3);
    run_until(1'b1, 200, n);
    check_vec("low_slow_again", n, 64);

    // Step mode with a bouncing button
    runMode = 1'b0;
    do_reset();
    repeat (12) @(negedge fastClk);
    check_vec("step_idle", 32'(cpuClk), 0);
    r0 = rise_cnt;
    f0 = fall_cnt;
    stepButton = 1'b1;
    @(negedge fastClk) stepButton = 1'b0;
    @(negedge fastClk) stepButton = 1'b1;
    @(negedge fastClk) stepButton = 1'b0;
    @(negedge fastClk) stepButton = 1'b1;
    run_until(1'b1, 50, n);
    check_vec("step_rise_latency", n, 7);
    check_vec("step_rise_strobe", 32'(clkRise), 1);
    run_until(1'b0, 50, n);
    check_vec("step_high", n, 3);
    check_vec("step_fall_strobe", 32'(clkFall), 1);
    repeat (20) @(negedge fastClk);
    check_vec("step_one_rise", rise_cnt - r0, 1);
    check_vec("step_one_fall", fall_cnt - f0, 1);

    // Re-press during HIGH_STEP and long hold
    stepButton = 1'b0;
    repeat (12) @(negedge fastClk);
    r0 = rise_cnt;
    stepButton = 1'b1;
    run_until(1'b1, 50, n);
    check_vec("press2_latency", n, 7);
    @(negedge fastClk) stepButton = 1'b0;
    @(negedge fastClk) stepButton = 1'b1;
    repeat (100) @(negedge fastClk);
    check_vec("held_one_pulse", rise_cnt - r0, 1);
    stepButton = 1'b0;
    repeat (12) @(negedge fastClk);

    // Press while halted is discarded, not queued
    halt = 1'b1;
    repeat (3) @(negedge fastClk);
    check_vec("step_halted", 32'(halted), 1);
    r0 = rise_cnt;
    stepButton = 1'b1;
    repeat (20) @(negedge fastClk);
    halt = 1'b0;
    repeat (20) @(negedge fastClk);
    check_vec("halt_discard", rise_cnt - r0, 0);
    check_vec("unhalted", 32'(halted), 0);
    stepButton = 1'b0;
    repeat (12) @(negedge fastClk);

    // Halt in run mode, speedSel=2
    runMode  = 1'b1;
    speedSel = 2'd2;
    run_until(1'b1, 50, n);
    check_vec("switch_to_run_rise", n, 4);
    @(negedge fastClk) halt = 1'b1;
    run_until(1'b0, 50, n);
    check_vec("halt_high_completes", n, 4);
    check_vec("halt_fall_strobe", 32'(clkFall), 1);
    check_vec("halted_at_fall", 32'(halted), 1);
    r0 = rise_cnt;
    repeat (20) @(negedge fastClk);
    check_vec("halt_no_rise", rise_cnt - r0, 0);
    check_vec("halt_clk_low", 32'(cpuClk), 0);
    check_vec("halt_halted", 32'(halted), 1);
    halt = 1'b0;
    run_until(1'b1, 50, n);
    check_vec("halt_release_rise", n, 4);
    check_vec("halt_release_flag", 32'(halted), 0);

    // Run -> step mid high phase, then back
    @(negedge fastClk) runMode = 1'b0;
    run_until(1'b0, 50, n);
    check_vec("mode_high_completes", n, 4);
    r0 = rise_cnt;
    repeat (30) @(negedge fastClk);
    check_vec("step_no_run_edges", rise_cnt - r0, 0);
    stepButton = 1'b1;
    run_until(1'b1, 50, n);
    check_vec("step_after_run", n, 7);
    run_until(1'b0, 50, n);
    check_vec("step_after_run_high", n, 3);
    stepButton = 1'b0;
    repeat (12) @(negedge fastClk);
    runMode = 1'b1;
    run_until(1'b1, 50, n);
    check_vec("run_restart", n, 4);

    // Asynchronous reset during HIGH_STEP with button held
    @(negedge fastClk) runMode = 1'b0;
    run_until(1'b0, 50, n);
    check_vec("last_run_high", n, 4);
    @(negedge fastClk) stepButton = 1'b1;
    run_until(1'b1, 50, n);
    check_vec("pre_rst_rise", n, 7);
    #2;
    resetN = 1'b0;
    #1;
    check_vec("async_rst_cpuClk", 32'(cpuClk), 0);
    check_vec("async_rst_clkRise", 32'(clkRise), 0);
    check_vec("async_rst_clkFall", 32'(clkFall), 0);
    check_vec("async_rst_halted", 32'(halted), 0);
    @(negedge fastClk) resetN = 1'b1;
    r0 = rise_cnt;
    repeat (40) @(negedge fastClk);
    check_vec("held_thru_rst_no_press", rise_cnt - r0, 0);
    stepButton = 1'b0;
    repeat (20) @(negedge fastClk);
    stepButton = 1'b1;
    run_until(1'b1, 50, n);
    check_vec("press_after_rst", n, 7);
    stepButton = 1'b0;
    repeat (10) @(negedge fastClk);

    check_vec("strobes_never_both", both_cnt, 0);
    check_vec("strobes_single_cycle", dup_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cpu_clock_gen.md
Name: cpu_clock_gen

Overview:
Second-generation CPU clock source for the 8-bit computer on the iCE40. It produces the CPU clock and runs entirely in the 12 MHz fastClk domain.
- Run mode: a free-running divided clock with a selectable speed.
- Step mode: exactly one fixed-width pulse per debounced button press.
- Halt stops the clock glitch-free, and mode changes are glitch-free.
- Single-cycle rise/fall strobes are provided so downstream logic can use clock enables instead of a derived clock.

Parameters:
BASE_HALF_PERIOD, 6000000, fastClk cycles per cpuClk phase at speedSel=0 (1 Hz at 12 MHz)
SPEED_W, 2, width of speedSel
DEBOUNCE_CYCLES, 12000, consecutive stable fastClk cycles needed to accept a button level (1 ms)
PULSE_CYCLES, 600000, high time of a step-mode pulse in fastClk cycles (50 ms)

Ports:
fastClk  in  1  system clock, 12 MHz; the only clock
resetN  in  1  asynchronous active-low reset
runMode  in  1  1 = free-run, 0 = single-step
speedSel  in  SPEED_W  run-mode speed; half period = BASE_HALF_PERIOD >> (2*speedSel)
stepButton  in  1  raw asynchronous push button, active high
halt  in  1  CPU halt request, synchronous to fastClk
cpuClk  out  1  registered CPU clock level
clkRise  out  1  one-cycle strobe, asserted on the same cycle cpuClk goes 0->1
clkFall  out  1  one-cycle strobe, asserted on the same cycle cpuClk goes 1->0
halted  out  1  registered; 1 while halt=1 and cpuClk=0

Behaviour:
- Reset (asynchronous, active-low):
  - cpuClk, clkRise, clkFall and halted = 0.
  - Sync flops, debounced level, counters = 0.
  - activeMode = step; FSM = LOW.
- Button path:
  - Two-flop synchroniser feeds the debouncer.
  - The debounced level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is a 0->1 change of the debounced level.
- Mode and speed sampling:
  - activeMode <= runMode only while FSM = LOW.
  - On a step->run switch, the phase counter clears.
  - Run-mode half period H is latched at the start of every phase; a speedSel change never truncates or extends the current phase.
- FSM states: LOW, HIGH_RUN, HIGH_STEP.
  - LOW, run mode, halt=0: the counter increments. When it reaches H-1, go to HIGH_RUN, set cpuClk=1, pulse clkRise, clear the counter.
  - HIGH_RUN: after H cycles, go to LOW, set cpuClk=0, pulse clkFall. Each phase lasts exactly H cycles.
  - LOW, step mode, halt=0, press event: on the next cycle go to HIGH_STEP, set cpuClk=1, pulse clkRise.
  - HIGH_STEP: after PULSE_CYCLES, go to LOW and pulse clkFall.
  - Press events while HIGH_STEP or halted are discarded, not queued.
- Halt:
  - Sampled only in LOW. A high phase always completes, with the normal clkFall.
  - While halt=1 in LOW: no rise, and the run counter holds at 0.
  - On deassertion, the first rise comes H cycles later.
- Strobe timing: clkRise and clkFall are never both high, and are never high for two consecutive cycles.
- Counter widths: each sized by $clog2 of its maximum value. speedSel values that would make H < 1 clamp H to 1.

Test Plan:
Use test params BASE_HALF_PERIOD=64, DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, SPEED_W=2.
1. Reset, runMode=1, speedSel=0 -> cpuClk rises at cycle 64 after reset release; 64 high / 64 low thereafter; clkRise/clkFall one cycle each. speedSel=2 -> phases of 4 cycles. speedSel changed mid-phase -> the current phase keeps its old length.
2. runMode=0; stepButton bounces 1-0-1-0 (1 cycle each), then a clean press -> cpuClk rises exactly 2+4+1 cycles after the last edge, stays high 3 cycles, and exactly one clkRise/clkFall pair occurs.
3. Step mode; a second press starts while HIGH_STEP -> no extra pulse. Press held 100 cycles -> only one pulse.
4. Run mode, speedSel=2; halt asserted during a high phase -> high completes 4 cycles, then cpuClk stays 0 and halted=1. Halt released -> first rise 4 cycles later.
5. runMode toggled 1->0 mid high phase -> the phase completes; no further run edges; the next pulse comes only from a press. Toggle back 0->1 -> the counter restarts at 0.
6. resetN asserted mid HIGH_STEP -> cpuClk, clkRise, clkFall and halted are 0 immediately (asynchronous). The held button is re-debounced after release of reset, and an already-pressed button does not generate a press event.
